button_bounce_gen: RTL

- Synthesizable generator that turns clean press/release commands into a realistic active-low bouncing button waveform.
- Drives the noisy input of debouncer instances for on-chip self-test and for closed-loop benches.
- Emits a bounded burst of pseudo-random glitch pairs, then a final settling edge, then holds the new level until the next command.
- Gap lengths come from an internal LFSR, so waveforms are deterministic for a given seed.

---
 rtl/button_bounce_gen.sv | 132 +++++++++++++
 1 files changed

// File: rtl/button_bounce_gen.sv
// button_bounce_gen
//   Turns clean press/release strobes into a bouncing active-low button
//   waveform. Each accepted command emits 2*BOUNCES+1 edges separated by
//   pseudo-random gaps and then holds the new level. The gaps come from an
//   8-bit LFSR, so a given seed always gives the same waveform.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   press_req    in   one-cycle strobe, start a press burst (accepted in IDLE)
//   release_req  in   one-cycle strobe, start a release burst (accepted in HELD)
//   noisy_button out  registered bouncing active-low button level
//   busy         out  high while a burst is in progress
//   pressed      out  high once a press burst has settled, until a release settles
//   done         out  one-cycle pulse on the settling edge of a burst
module button_bounce_gen #(
  parameter int         BOUNCES  = 2,
  parameter int         MIN_GAP  = 2,
  parameter int         GAP_BITS = 2,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic press_req,
  input  logic release_req,
  output logic noisy_button,
  output logic busy,
  output logic pressed,
  output logic done
);

  localparam int EDGES   = 2 * BOUNCES + 1;
  localparam int EDGE_W  = $clog2(2 * BOUNCES + 2);
  localparam int GAP_MAX = MIN_GAP + (1 << GAP_BITS) - 1;
  localparam int GAP_W   = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);

  // An all-zero LFSR would lock up, so a zero seed is forced to 1.
  localparam logic [7:0]        LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0]        GAP_MASK  = 8'((1 << GAP_BITS) - 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(EDGES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_BOUNCE,
    S_HELD,
    S_RELEASE_BOUNCE
  } state_t;

  state_t            r_state;
  logic [7:0]        r_lfsr;
  logic [EDGE_W-1:0] r_edge_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_noisy;
  logic              r_busy;
  logic              r_pressed;
  logic              r_done;

  logic [7:0]        w_lfsr_next;
  logic [7:0]        w_rand;
  logic [GAP_W-1:0]  w_gap_reload;
  logic              w_last;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left.
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // The gap counter holds (gap - 1) so that a zero count means "emit an
  // edge on this clock"; gap = MIN_GAP + low GAP_BITS of the LFSR.
  assign w_rand       = r_lfsr & GAP_MASK;
  assign w_gap_reload = GAP_W'(MIN_GAP - 1) + GAP_W'(w_rand);
  assign w_last       = (r_edge_cnt == LAST_EDGE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_lfsr     <= LFSR_INIT;
      r_edge_cnt <= '0;
      r_gap_cnt  <= '0;
      r_noisy    <= 1'b1;
      r_busy     <= 1'b0;
      r_pressed  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Zero gap count makes the first edge appear on the next clock.
          if (press_req) begin
            r_state    <= S_PRESS_BOUNCE;
            r_edge_cnt <= '0;
            r_gap_cnt  <= '0;
          end
        end
        S_HELD: begin
          if (release_req) begin
            r_state    <= S_RELEASE_BOUNCE;
            r_edge_cnt <= '0;
            r_gap_cnt  <= '0;
          end
        end
        S_PRESS_BOUNCE, S_RELEASE_BOUNCE: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end else begin
            // Every emitted edge, including the last, advances the LFSR once.
            r_lfsr    <= w_lfsr_next;
            r_gap_cnt <= w_gap_reload;
            if (w_last) begin
              // The settling level is forced rather than toggled so the
              // final level is correct by construction.
              r_noisy   <= (r_state == S_RELEASE_BOUNCE);
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_pressed <= (r_state == S_PRESS_BOUNCE);
              r_state   <= (r_state == S_PRESS_BOUNCE) ? S_HELD : S_IDLE;
            end else begin
              r_noisy    <= ~r_noisy;
              r_busy     <= 1'b1;
              r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign noisy_button = r_noisy;
  assign busy         = r_busy;
  assign pressed      = r_pressed;
  assign done         = r_done;

endmodule
